ko_overlay_ctrl: RTL and testbench
==================================

# ko_overlay_ctrl

Sequences the end-of-round "KO" banner and composites it onto the game frame for the 96x64 OLED. It consumes the per-pixel colour from the KO text glyph ROM and the game renderer's background colour. It then produces the final registered pixel colour for the OLED driver. A timed blink → hold → done sequence is paced in whole display frames, so the overlay never tears mid-frame.

## Interface
Parameters:
- BLINK_FRAMES, 8, frames per blink phase (ON or OFF); must be ≥1
- BLINK_COUNT, 3, number of ON/OFF blink pairs; must be ≥1
- HOLD_FRAMES, 60, frames of steady text after blinking; must be ≥1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_begin  in  1  one-cycle pulse from the OLED driver, ≥1 cycle before pixel_index 0 of each frame
- ko_trigger  in  1  one-cycle pulse from game logic when a player's health reaches 0
- ack  in  1  one-cycle pulse from the round FSM requesting return to normal display
- text_colour  in  16  RGB565 from the KO text ROM; 16'h0000 means "not a text pixel"
- bg_colour  in  16  RGB565 from the game renderer for the same pixel
- oled_colour  out  16  composited RGB565 pixel, registered
- ko_active  out  1  high in every state except IDLE; used to freeze player input
- ko_done  out  1  high only in DONE

## Operation
- States: IDLE, FLASH_ON, FLASH_OFF, HOLD, DONE.
- Pending flags: `trig_pend` is set by ko_trigger in IDLE and ignored elsewhere. `ack_pend` is set by ack in DONE and ignored elsewhere.
- All state transitions occur only on a cycle with frame_begin=1.
- IDLE: on frame_begin with trig_pend=1, go to FLASH_ON, clear trig_pend, set frame_cnt=0 and blink_cnt=0.
- Phase counting (FLASH_ON, FLASH_OFF, HOLD):
  - frame_cnt is cleared on phase entry.
  - On each later frame_begin, if frame_cnt == N-1, take the exit; otherwise increment frame_cnt.
  - Each phase therefore lasts exactly N frames.
- FLASH_ON exits (N=BLINK_FRAMES) to FLASH_OFF.
- FLASH_OFF exits (N=BLINK_FRAMES):
  - If blink_cnt == BLINK_COUNT-1, go to HOLD.
  - Otherwise increment blink_cnt and go to FLASH_ON.
- HOLD exits (N=HOLD_FRAMES) to DONE.
- DONE: on frame_begin with ack_pend=1, go to IDLE and clear ack_pend.
- Same-cycle events:
  - ko_trigger together with frame_begin in IDLE: the trigger is pending for the *next* frame_begin, not the current one.
  - ack and ko_trigger together in IDLE: ack is ignored and the trigger is latched.
- Compositing:
  - The dim function halves each field: dim(c) = {1'b0,c[15:12], 1'b0,c[10:6], 1'b0,c[4:1]}.
  - IDLE: output bg_colour.
  - FLASH_OFF: output dim(bg_colour).
  - FLASH_ON, HOLD, DONE: output text_colour if it is non-zero, otherwise dim(bg_colour).
- Counter widths: frame_cnt and blink_cnt are $clog2(max parameter)+1 bits. No wrap-around is reachable.

## Timing
- oled_colour is registered: the value at cycle t+1 is computed from text_colour, bg_colour and the state at cycle t (pre-transition). Latency is 1 cycle.
- A state change on a frame_begin edge takes effect for every pixel of the frame that follows.
- ko_active and ko_done are registered decodes of the state and change in the cycle after the transition edge.
- Reset (asynchronous, any time including mid-sequence) forces:
  - state = IDLE
  - all counters = 0 and both pending flags cleared
  - oled_colour = 16'h0000, ko_active = 0, ko_done = 0
- After reset deasserts, the first clock edge outputs bg_colour.

## Test plan
- Reset: assert reset mid-HOLD → the same cycle shows oled_colour=0000, ko_active=0, ko_done=0. After release with bg=F800, the output is F800 and the block stays IDLE through 5 frames.
- Sequence, with BLINK_FRAMES=2, BLINK_COUNT=2, HOLD_FRAMES=3: pulse ko_trigger, then frame_begin pulses #1..#12 → states after each pulse:
  - #1 FLASH_ON
  - #3 FLASH_OFF
  - #5 FLASH_ON
  - #7 FLASH_OFF
  - #9 HOLD
  - #12 DONE, with ko_done=1 from the next cycle
- Compositing, with bg=FFFF:
  - text=FFFF: FLASH_ON → FFFF; FLASH_OFF → 7BEF.
  - text=0000: FLASH_ON → 7BEF; IDLE → FFFF.
  - bg=F800, text=0000 in HOLD → 7800.
- Ignored inputs: a ko_trigger during FLASH_OFF does not restart the sequence (same #12 DONE timing). An ack during HOLD has no effect, and DONE is still reached and held.
- Ack handshake: ack in DONE mid-frame → state remains DONE until the next frame_begin, then IDLE. ko_active falls 1 cycle later and oled_colour returns to bg.
- Same-cycle trigger: ko_trigger and frame_begin in the same cycle in IDLE → still IDLE after that edge; FLASH_ON after the following frame_begin.

Source files
------------

// File: rtl/ko_overlay_ctrl.sv
// ko_overlay_ctrl: frame-paced KO banner sequencer and pixel compositor for the OLED
module ko_overlay_ctrl #(
    parameter int BLINK_FRAMES = 8,
    parameter int BLINK_COUNT  = 3,
    parameter int HOLD_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic        ko_trigger,
    input  logic        ack,
    input  logic [15:0] text_colour,
    input  logic [15:0] bg_colour,
    output logic [15:0] oled_colour,
    output logic        ko_active,
    output logic        ko_done
);
    localparam int MAXP = (BLINK_FRAMES > BLINK_COUNT) ?
                          ((BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES) :
                          ((BLINK_COUNT > HOLD_FRAMES) ? BLINK_COUNT : HOLD_FRAMES);
    localparam int CW = $clog2(MAXP) + 1;
    typedef enum logic [2:0] {IDLE, FLASH_ON, FLASH_OFF, HOLD, DONE} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  frame_q, frame_d, blink_q, blink_d, phase_last;
    logic           trig_q, trig_d, ack_q, ack_d, last;
    logic [15:0]    oled_d, bg_dim;
    assign bg_dim     = {1'b0, bg_colour[15:12], 1'b0, bg_colour[10:6], 1'b0, bg_colour[4:1]};
    assign phase_last = (state_q == HOLD) ? CW'(HOLD_FRAMES - 1) : CW'(BLINK_FRAMES - 1);
    assign last       = frame_q == phase_last;
    // next state: pending flags latch anywhere in the frame, transitions only on frame_begin
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        blink_d = blink_q;
        trig_d  = trig_q | (state_q == IDLE && ko_trigger);
        ack_d   = ack_q | (state_q == DONE && ack);
        if (frame_begin) begin
            case (state_q)
                IDLE: if (trig_q) begin
                    state_d = FLASH_ON;
                    trig_d  = 1'b0;
                    frame_d = '0;
                    blink_d = '0;
                end
                FLASH_ON: begin
                    frame_d = last ? '0 : frame_q + 1'b1;
                    state_d = last ? FLASH_OFF : FLASH_ON;
                end
                FLASH_OFF: begin
                    frame_d = last ? '0 : frame_q + 1'b1;
                    if (last && blink_q == CW'(BLINK_COUNT - 1)) state_d = HOLD;
                    else if (last) begin
                        state_d = FLASH_ON;
                        blink_d = blink_q + 1'b1;
                    end
                end
                HOLD: begin
                    frame_d = last ? '0 : frame_q + 1'b1;
                    state_d = last ? DONE : HOLD;
                end
                DONE: if (ack_q) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // pixel composite from the pre-transition state
    always_comb begin
        oled_d = (state_q == IDLE)      ? bg_colour :
                 (state_q == FLASH_OFF) ? bg_dim :
                 (|text_colour)         ? text_colour : bg_dim;
    end
    // all state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            blink_q     <= '0;
            trig_q      <= 1'b0;
            ack_q       <= 1'b0;
            oled_colour <= 16'h0000;
            ko_active   <= 1'b0;
            ko_done     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            blink_q     <= blink_d;
            trig_q      <= trig_d;
            ack_q       <= ack_d;
            oled_colour <= oled_d;
            ko_active   <= state_q != IDLE;
            ko_done     <= state_q == DONE;
        end
    end
endmodule

// File: tb/tb_ko_overlay_ctrl.sv
// tb_ko_overlay_ctrl: directed and random checks of the KO overlay against a frame-schedule model
module tb_ko_overlay_ctrl;
    localparam int BF = 2, BC = 2, HF = 3;
    localparam int S_IDLE = 0, S_ON = 1, S_OFF = 2, S_HOLD = 3, S_DONE = 4;
    logic        clk = 1'b0, reset = 1'b1, frame_begin = 1'b0, ko_trigger = 1'b0, ack = 1'b0;
    logic [15:0] text_colour = 16'h0000, bg_colour = 16'hF800;
    logic [15:0] oled_colour;
    logic        ko_active, ko_done;
    int          n_pass = 0, n_tot = 0;
    bit          m_run = 0, m_trig = 0, m_ack = 0;
    int          m_f = 0;
    logic [15:0] e_oled = 16'h0000;
    logic        e_act = 1'b0, e_done = 1'b0;

    ko_overlay_ctrl #(.BLINK_FRAMES(BF), .BLINK_COUNT(BC), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .reset(reset), .frame_begin(frame_begin), .ko_trigger(ko_trigger), .ack(ack),
        .text_colour(text_colour), .bg_colour(bg_colour),
        .oled_colour(oled_colour), .ko_active(ko_active), .ko_done(ko_done)
    );

    always #5 clk = ~clk;

    // state implied by how many frames have elapsed since the sequence started
    function automatic int st_of(bit run, int f);
        if (!run) return S_IDLE;
        if (f < 2 * BF * BC) return ((f / BF) % 2 == 0) ? S_ON : S_OFF;
        if (f < 2 * BF * BC + HF) return S_HOLD;
        return S_DONE;
    endfunction

    function automatic logic [15:0] dimf(logic [15:0] c);
        return (((c >> 12) & 16'h000F) << 11) | (((c >> 6) & 16'h001F) << 5) | ((c >> 1) & 16'h000F);
    endfunction

    task automatic chk(string nm, logic [15:0] a, logic [15:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    endtask

    // reference model
    always @(posedge clk or posedge reset) begin : model_p
        int s;
        bit tp, ap;
        if (reset) begin
            m_run <= 0; m_f <= 0; m_trig <= 0; m_ack <= 0;
            e_oled <= 16'h0000; e_act <= 1'b0; e_done <= 1'b0;
        end else begin
            s  = st_of(m_run, m_f);
            tp = m_trig | (s == S_IDLE && ko_trigger);
            ap = m_ack | (s == S_DONE && ack);
            e_oled <= (s == S_IDLE) ? bg_colour : (s == S_OFF) ? dimf(bg_colour) :
                      (text_colour != 0) ? text_colour : dimf(bg_colour);
            e_act  <= s != S_IDLE;
            e_done <= s == S_DONE;
            if (frame_begin && s == S_IDLE && m_trig) begin
                m_run <= 1; m_f <= 0; tp = 0;
            end else if (frame_begin && s == S_DONE && m_ack) begin
                m_run <= 0; m_f <= 0; ap = 0;
            end else if (frame_begin && s != S_IDLE && s != S_DONE) m_f <= m_f + 1;
            m_trig <= tp;
            m_ack  <= ap;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        chk("oled", oled_colour, e_oled);
        chk("ko_active", {15'b0, ko_active}, {15'b0, e_act});
        chk("ko_done", {15'b0, ko_done}, {15'b0, e_done});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic frame();
        frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        tick();
        chk("lit_reset_bg", oled_colour, 16'hF800);
        repeat (5) frame();
        chk("lit_idle_active", {15'b0, ko_active}, 16'h0000);
        // main sequence
        bg_colour = 16'hFFFF; text_colour = 16'hFFFF;
        ko_trigger = 1'b1; tick(); ko_trigger = 1'b0; tick();
        frame();
        chk("lit_f1_state", 16'(st_of(m_run, m_f)), 16'(S_ON));
        chk("lit_on_text", oled_colour, 16'hFFFF);
        chk("lit_on_active", {15'b0, ko_active}, 16'h0001);
        repeat (2) frame();
        chk("lit_f3_state", 16'(st_of(m_run, m_f)), 16'(S_OFF));
        chk("lit_off_dim", oled_colour, 16'h7BEF);
        text_colour = 16'h0000;
        repeat (2) frame();
        chk("lit_f5_state", 16'(st_of(m_run, m_f)), 16'(S_ON));
        chk("lit_on_notext", oled_colour, 16'h7BEF);
        frame();
        frame_begin = 1'b1; tick(); frame_begin = 1'b0;
        ko_trigger = 1'b1; tick(); ko_trigger = 1'b0; repeat (2) tick();
        chk("lit_f7_state", 16'(st_of(m_run, m_f)), 16'(S_OFF));
        bg_colour = 16'hF800;
        repeat (2) frame();
        chk("lit_f9_state", 16'(st_of(m_run, m_f)), 16'(S_HOLD));
        chk("lit_hold_dim", oled_colour, 16'h7800);
        frame_begin = 1'b1; tick(); frame_begin = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0; repeat (2) tick();
        frame();
        chk("lit_f11_done", {15'b0, ko_done}, 16'h0000);
        frame_begin = 1'b1; tick(); frame_begin = 1'b0;
        chk("lit_f12_state", 16'(st_of(m_run, m_f)), 16'(S_DONE));
        chk("lit_f12_done_lag", {15'b0, ko_done}, 16'h0000);
        tick();
        chk("lit_f12_done", {15'b0, ko_done}, 16'h0001);
        frame();
        chk("lit_done_held", {15'b0, ko_done}, 16'h0001);
        // ack handshake
        ack = 1'b1; tick(); ack = 1'b0; repeat (3) tick();
        chk("lit_ack_wait", {15'b0, ko_done}, 16'h0001);
        frame_begin = 1'b1; tick(); frame_begin = 1'b0;
        chk("lit_ack_active_lag", {15'b0, ko_active}, 16'h0001);
        tick();
        chk("lit_ack_active", {15'b0, ko_active}, 16'h0000);
        chk("lit_ack_bg", oled_colour, 16'hF800);
        // trigger coinciding with frame_begin
        repeat (2) tick();
        ko_trigger = 1'b1; frame_begin = 1'b1; tick(); ko_trigger = 1'b0; frame_begin = 1'b0;
        repeat (3) tick();
        chk("lit_same_idle", {15'b0, ko_active}, 16'h0000);
        frame();
        chk("lit_same_on", {15'b0, ko_active}, 16'h0001);
        // reset in HOLD
        for (int i = 0; i < 40 && st_of(m_run, m_f) != S_HOLD; i++) frame();
        chk("lit_reached_hold", 16'(st_of(m_run, m_f)), 16'(S_HOLD));
        #1 reset = 1'b1;
        #1;
        chk("lit_rst_oled", oled_colour, 16'h0000);
        chk("lit_rst_active", {15'b0, ko_active}, 16'h0000);
        chk("lit_rst_done", {15'b0, ko_done}, 16'h0000);
        bg_colour = 16'hF800;
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        chk("lit_rst_bg", oled_colour, 16'hF800);
        repeat (5) frame();
        chk("lit_rst_idle", {15'b0, ko_active}, 16'h0000);
        // randomized traffic
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            frame_begin = (cnt == 0);
            cnt = (cnt == 0) ? int'($urandom_range(2, 8)) : cnt - 1;
            ko_trigger  = ($urandom % 16) == 0;
            ack         = ($urandom % 8) == 0;
            text_colour = ($urandom % 2) ? 16'h0000 : 16'($urandom);
            bg_colour   = 16'($urandom);
            tick();
        end
        frame_begin = 1'b0; ko_trigger = 1'b0; ack = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
